bus_arbiter_2: RTL and testbench



---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_watchdog.sv | 45 ++++
 rtl/bus_arbiter_2.sv | 195 +++++++++++++++++++
 tb/tb_bus_arbiter_2.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the 32-bit data bus arbiter.
//   arb_state_t           : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   BUS_AW / BUS_DW       : address / data widths
//   BUS_MW                : byte-lane write-mask width
//   DEFAULT_TIMEOUT_RDATA : read data returned on a timed-out read
// ----------------------------------------------------------------------------
package bus_pkg;

   localparam int unsigned BUS_AW = 32;
   localparam int unsigned BUS_DW = 32;
   localparam int unsigned BUS_MW = 4;

   localparam logic [BUS_DW-1:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/bus_watchdog.sv
// ----------------------------------------------------------------------------
// bus_watchdog
// Saturating cycle counter that flags when a granted transaction has run for
// TIMEOUT_CYCLES cycles without completing. TIMEOUT_CYCLES = 0 disables it.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   clear  in  zero the counter (held while the arbiter is idle)
//   enable in  count this cycle (granted and target not done)
//   expire out counter has reached TIMEOUT_CYCLES-1 (last allowed cycle)
// ----------------------------------------------------------------------------
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expire        = 1'b0;
   end else begin : g_counter
      localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

      logic [CNT_W-1:0] wd_cnt;

      // Saturates at TIMEOUT_CYCLES so it can never wrap back into range.
      always_ff @(posedge clk) begin
         if (rst || clear) begin
            wd_cnt <= '0;
         end else if (enable && (wd_cnt != CNT_MAX)) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
      end

      assign expire = (wd_cnt == CNT_LAST);
   end

endmodule

// File: rtl/bus_arbiter_2.sv
// ----------------------------------------------------------------------------
// bus_arbiter_2
// Two-host to one-target arbiter for the addr/wdata/wmask/rdata/wen/ren/done
// data bus. One host is granted per transaction (round-robin or fixed
// priority); a watchdog force-completes transactions the target never ends.
// Parameters:
//   FIXED_PRIORITY : 0 = round-robin, 1 = host 0 wins ties
//   TIMEOUT_CYCLES : granted cycles allowed without t_done (0 = no watchdog)
//   TIMEOUT_RDATA  : read data returned on a timed-out read
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   hN_addr/wdata/wmask/wen/ren  host N request, held until hN_done
//   hN_rdata/done/err            host N response (zero unless done)
//   t_addr/wdata/wmask/wen/ren   request forwarded to the target
//   t_rdata/t_done               target response
// ----------------------------------------------------------------------------
module bus_arbiter_2
   import bus_pkg::*;
#(
   parameter int unsigned       FIXED_PRIORITY = 0,
   parameter int unsigned       TIMEOUT_CYCLES = 1024,
   parameter logic [BUS_DW-1:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
   input  logic              clk,
   input  logic              rst,
   // host 0
   input  logic [BUS_AW-1:0] h0_addr,
   input  logic [BUS_DW-1:0] h0_wdata,
   input  logic [BUS_MW-1:0] h0_wmask,
   input  logic              h0_wen,
   input  logic              h0_ren,
   output logic [BUS_DW-1:0] h0_rdata,
   output logic              h0_done,
   output logic              h0_err,
   // host 1
   input  logic [BUS_AW-1:0] h1_addr,
   input  logic [BUS_DW-1:0] h1_wdata,
   input  logic [BUS_MW-1:0] h1_wmask,
   input  logic              h1_wen,
   input  logic              h1_ren,
   output logic [BUS_DW-1:0] h1_rdata,
   output logic              h1_done,
   output logic              h1_err,
   // target
   output logic [BUS_AW-1:0] t_addr,
   output logic [BUS_DW-1:0] t_wdata,
   output logic [BUS_MW-1:0] t_wmask,
   output logic              t_wen,
   output logic              t_ren,
   input  logic [BUS_DW-1:0] t_rdata,
   input  logic              t_done
);

   arb_state_t state_q, state_d;
   logic       last_grant_q, last_grant_d;

   logic       req0, req1;
   logic       granted;
   logic       wd_expire;
   logic       timeout;

   assign req0    = h0_ren | h0_wen;
   assign req1    = h1_ren | h1_wen;
   assign granted = (state_q != IDLE);

   // Timeout fires only if the target has not completed in the last cycle.
   assign timeout = granted && wd_expire && !t_done;

   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (!granted),
      .enable (granted && !t_done),
      .expire (wd_expire)
   );

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;  // host 0 wins the first round-robin tie
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               if ((FIXED_PRIORITY != 0) || last_grant_q) begin
                  state_d      = GRANT0;
                  last_grant_d = 1'b0;
               end else begin
                  state_d      = GRANT1;
                  last_grant_d = 1'b1;
               end
            end else if (req0) begin
               state_d      = GRANT0;
               last_grant_d = 1'b0;
            end else if (req1) begin
               state_d      = GRANT1;
               last_grant_d = 1'b1;
            end
         end
         // Always return through IDLE so a host still holding its request in
         // its done cycle is not granted a second time.
         GRANT0, GRANT1: begin
            if (t_done || timeout) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Forwarded address/data/mask (independent of the target response, so no
   // combinational path exists from t_done back to these outputs)
   // -------------------------------------------------------------------------
   always_comb begin
      t_addr  = '0;
      t_wdata = '0;
      t_wmask = '0;
      if (!rst) begin
         unique case (state_q)
            GRANT0: begin
               t_addr  = h0_addr;
               t_wdata = h0_wdata;
               t_wmask = h0_wmask;
            end
            GRANT1: begin
               t_addr  = h1_addr;
               t_wdata = h1_wdata;
               t_wmask = h1_wmask;
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Strobes and host responses
   // -------------------------------------------------------------------------
   always_comb begin
      t_wen    = 1'b0;
      t_ren    = 1'b0;
      h0_done  = 1'b0;
      h0_err   = 1'b0;
      h0_rdata = '0;
      h1_done  = 1'b0;
      h1_err   = 1'b0;
      h1_rdata = '0;
      if (!rst) begin
         unique case (state_q)
            GRANT0: begin
               // Strobes drop in the timeout cycle so the target sees the
               // transaction withdrawn.
               t_wen   = h0_wen && !timeout;
               t_ren   = h0_ren && !timeout;
               h0_done = t_done || timeout;
               h0_err  = timeout;
               if (timeout) begin
                  h0_rdata = h0_ren ? TIMEOUT_RDATA : '0;
               end else if (t_done) begin
                  h0_rdata = t_rdata;
               end
            end
            GRANT1: begin
               t_wen   = h1_wen && !timeout;
               t_ren   = h1_ren && !timeout;
               h1_done = t_done || timeout;
               h1_err  = timeout;
               if (timeout) begin
                  h1_rdata = h1_ren ? TIMEOUT_RDATA : '0;
               end else if (t_done) begin
                  h1_rdata = t_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_2.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter_2
// Directed scoreboard bench. Host tasks push the expected response when a
// request is issued; a negedge monitor pops and compares on every done.
// dut runs round-robin with an 8-cycle watchdog; dut_fp runs fixed priority
// and is only out of reset for the final fixed-priority scenario.
// ----------------------------------------------------------------------------
module tb_bus_arbiter_2;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rst_fp, use_fp;

   logic [31:0] h0_addr, h0_wdata, h1_addr, h1_wdata;
   logic [3:0]  h0_wmask, h1_wmask;
   logic        h0_wen, h0_ren, h1_wen, h1_ren;

   // round-robin instance outputs
   logic [31:0] a_h0_rdata, a_h1_rdata, a_t_addr, a_t_wdata;
   logic        a_h0_done, a_h0_err, a_h1_done, a_h1_err, a_t_wen, a_t_ren;
   logic [3:0]  a_t_wmask;
   // fixed-priority instance outputs
   logic [31:0] b_h0_rdata, b_h1_rdata, b_t_addr, b_t_wdata;
   logic        b_h0_done, b_h0_err, b_h1_done, b_h1_err, b_t_wen, b_t_ren;
   logic [3:0]  b_t_wmask;
   // view of whichever instance is active
   logic [31:0] m_h0_rdata, m_h1_rdata, m_t_addr, m_t_wdata;
   logic        m_h0_done, m_h0_err, m_h1_done, m_h1_err, m_t_wen, m_t_ren;
   logic [3:0]  m_t_wmask;

   logic [31:0] t_rdata;
   logic        t_done;

   assign m_h0_rdata = use_fp ? b_h0_rdata : a_h0_rdata;
   assign m_h0_done  = use_fp ? b_h0_done  : a_h0_done;
   assign m_h0_err   = use_fp ? b_h0_err   : a_h0_err;
   assign m_h1_rdata = use_fp ? b_h1_rdata : a_h1_rdata;
   assign m_h1_done  = use_fp ? b_h1_done  : a_h1_done;
   assign m_h1_err   = use_fp ? b_h1_err   : a_h1_err;
   assign m_t_addr   = use_fp ? b_t_addr   : a_t_addr;
   assign m_t_wdata  = use_fp ? b_t_wdata  : a_t_wdata;
   assign m_t_wmask  = use_fp ? b_t_wmask  : a_t_wmask;
   assign m_t_wen    = use_fp ? b_t_wen    : a_t_wen;
   assign m_t_ren    = use_fp ? b_t_ren    : a_t_ren;

   bus_arbiter_2 #(
      .FIXED_PRIORITY (0),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk      (clk),      .rst      (rst),
      .h0_addr  (h0_addr),  .h0_wdata (h0_wdata), .h0_wmask (h0_wmask),
      .h0_wen   (h0_wen),   .h0_ren   (h0_ren),
      .h0_rdata (a_h0_rdata), .h0_done (a_h0_done), .h0_err (a_h0_err),
      .h1_addr  (h1_addr),  .h1_wdata (h1_wdata), .h1_wmask (h1_wmask),
      .h1_wen   (h1_wen),   .h1_ren   (h1_ren),
      .h1_rdata (a_h1_rdata), .h1_done (a_h1_done), .h1_err (a_h1_err),
      .t_addr   (a_t_addr), .t_wdata  (a_t_wdata), .t_wmask (a_t_wmask),
      .t_wen    (a_t_wen),  .t_ren    (a_t_ren),
      .t_rdata  (t_rdata),  .t_done   (t_done)
   );

   bus_arbiter_2 #(
      .FIXED_PRIORITY (1)
   ) dut_fp (
      .clk      (clk),      .rst      (rst_fp),
      .h0_addr  (h0_addr),  .h0_wdata (h0_wdata), .h0_wmask (h0_wmask),
      .h0_wen   (h0_wen),   .h0_ren   (h0_ren),
      .h0_rdata (b_h0_rdata), .h0_done (b_h0_done), .h0_err (b_h0_err),
      .h1_addr  (h1_addr),  .h1_wdata (h1_wdata), .h1_wmask (h1_wmask),
      .h1_wen   (h1_wen),   .h1_ren   (h1_ren),
      .h1_rdata (b_h1_rdata), .h1_done (b_h1_done), .h1_err (b_h1_err),
      .t_addr   (b_t_addr), .t_wdata  (b_t_wdata), .t_wmask (b_t_wmask),
      .t_wen    (b_t_wen),  .t_ren    (b_t_ren),
      .t_rdata  (t_rdata),  .t_done   (t_done)
   );

   // ------------------------------------------------------------------------
   // Target model: busy while a nonzero address is forwarded; completes after
   // tgt_wait wait cycles unless tgt_never. Read data comes from a fixed table.
   // ------------------------------------------------------------------------
   int   tgt_wait;
   bit   tgt_never;
   bit   stray;
   int   tgt_cnt = 0;
   logic sel_active;

   function automatic logic [31:0] tgt_lookup(input logic [31:0] a);
      case (a)
         32'h100: return 32'h1234_5678;
         32'h020: return 32'hCAFE_F00D;
         32'h200: return 32'hA000_0000;
         32'h204: return 32'hA000_0004;
         32'h208: return 32'hA000_0008;
         32'h300: return 32'h55AA_55AA;
         32'h030: return 32'h0BAD_CAFE;
         default: return 32'h0;
      endcase
   endfunction

   assign sel_active = (m_t_addr != 32'd0);
   assign t_done     = (sel_active && !tgt_never && (tgt_cnt == tgt_wait)) || stray;
   assign t_rdata    = t_done ? tgt_lookup(m_t_addr) : 32'd0;

   always @(posedge clk) begin
      tgt_cnt <= (sel_active && !t_done) ? tgt_cnt + 1 : 0;
   end

   // ------------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------------
   exp_t q0[$], q1[$];
   exp_t e0, e1;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_h0_done) begin
         if (q0.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL h0_unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
         end else begin
            e0 = q0.pop_front();
            check("h0_rdata", m_h0_rdata, e0.rdata);
            check("h0_err", 32'(m_h0_err), 32'(e0.err));
         end
      end else begin
         check("h0_quiet", m_h0_rdata | 32'(m_h0_err), 32'd0);
      end
      if (m_h1_done) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL h1_unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
         end else begin
            e1 = q1.pop_front();
            check("h1_rdata", m_h1_rdata, e1.rdata);
            check("h1_err", 32'(m_h1_err), 32'(e1.err));
         end
      end else begin
         check("h1_quiet", m_h1_rdata | 32'(m_h1_err), 32'd0);
      end
   end

   // ------------------------------------------------------------------------
   // Host driver: issue, wait for done (bounded), release. lat counts negedge
   // samples from the request cycle up to and including the done cycle.
   // ------------------------------------------------------------------------
   task automatic do_req(input int h, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m,
                         input logic [31:0] exp_rd, input bit exp_err, output int lat);
      exp_t e;
      bit   seen;
      e.rdata = exp_rd;
      e.err   = exp_err;
      if (h == 0) begin
         q0.push_back(e);
         h0_addr = a; h0_wdata = wd; h0_wmask = m; h0_wen = wr; h0_ren = !wr;
      end else begin
         q1.push_back(e);
         h1_addr = a; h1_wdata = wd; h1_wmask = m; h1_wen = wr; h1_ren = !wr;
      end
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         lat++;
         seen = (h == 0) ? m_h0_done : m_h1_done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL h%0d_done_wait: got no done expected done within 100 cycles", h);
      end
      @(posedge clk);
      #1;
      if (h == 0) begin
         h0_addr = '0; h0_wdata = '0; h0_wmask = '0; h0_wen = 1'b0; h0_ren = 1'b0;
      end else begin
         h1_addr = '0; h1_wdata = '0; h1_wmask = '0; h1_wen = 1'b0; h1_ren = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200us");
      $fatal(1, "simulation hung");
   end

   int lat0, lat1;
   logic [31:0] b2b_addr [3];
   logic [31:0] b2b_exp  [3];

   initial begin
      b2b_addr = '{32'h200, 32'h204, 32'h208};
      b2b_exp  = '{32'hA000_0000, 32'hA000_0004, 32'hA000_0008};
      rst = 1'b1; rst_fp = 1'b1; use_fp = 1'b0;
      tgt_wait = 0; tgt_never = 1'b0; stray = 1'b0;
      h0_addr = '0; h0_wdata = '0; h0_wmask = '0; h0_wen = 1'b0; h0_ren = 1'b0;
      h1_addr = '0; h1_wdata = '0; h1_wmask = '0; h1_wen = 1'b0; h1_ren = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_t_ren", 32'(m_t_ren), 32'd0);
      check("rst_t_wen", 32'(m_t_wen), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_t_addr", m_t_addr, 32'd0);

      // round-robin tie after reset: h0 first, twice in a row
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
         fork
            do_req(0, 1'b1, 32'h10, 32'hAA, 4'b0001, 32'h0, 1'b0, lat0);
            do_req(1, 1'b0, 32'h20, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0, lat1);
         join
         check("rr_h0_lat", 32'(lat0), 32'd2);
         check("rr_h1_lat", 32'(lat1), 32'd4);
      end

      // single zero-wait read, followed by an IDLE bubble
      do_reset();
      do_req(0, 1'b0, 32'h100, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, lat0);
      check("single_lat", 32'(lat0), 32'd2);
      @(negedge clk);
      check("bubble_t_ren", 32'(m_t_ren), 32'd0);
      check("bubble_t_addr", m_t_addr, 32'd0);

      // wait-state target; h1 arrives mid-grant
      tgt_wait = 5;
      @(posedge clk); #1;
      fork
         do_req(0, 1'b1, 32'h40, 32'hCAFE_0001, 4'b1010, 32'h0, 1'b0, lat0);
         begin
            repeat (3) @(posedge clk);
            #1;
            do_req(1, 1'b0, 32'h300, 32'h0, 4'b0000, 32'h55AA_55AA, 1'b0, lat1);
         end
         begin
            @(negedge clk);
            repeat (6) begin
               @(negedge clk);
               check("wait_t_wen", 32'(m_t_wen), 32'd1);
               check("wait_t_addr", m_t_addr, 32'h40);
               check("wait_t_wdata", m_t_wdata, 32'hCAFE_0001);
               check("wait_t_wmask", 32'(m_t_wmask), 32'hA);
            end
         end
      join
      check("wait_h0_lat", 32'(lat0), 32'd7);
      check("wait_h1_lat", 32'(lat1), 32'd11);

      // watchdog timeout on an h1 read, then a stray late t_done
      tgt_wait  = 0;
      tgt_never = 1'b1;
      @(posedge clk); #1;
      fork
         do_req(1, 1'b0, 32'h80, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1, lat1);
         begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
               @(negedge clk);
               if (m_h1_done) begin
                  hit = 1'b1;
                  check("timeout_t_ren", 32'(m_t_ren), 32'd0);
               end
            end
         end
      join
      check("timeout_lat", 32'(lat1), 32'd9);
      stray = 1'b1;
      @(negedge clk);
      check("stray_h1_done", 32'(m_h1_done), 32'd0);
      check("stray_h0_done", 32'(m_h0_done), 32'd0);
      @(posedge clk); #1;
      stray     = 1'b0;
      tgt_never = 1'b0;

      // reset in the second grant cycle of an h0 read
      tgt_wait = 5;
      @(posedge clk); #1;
      h0_addr = 32'h200; h0_ren = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_t_ren", 32'(m_t_ren), 32'd0);
      check("mid_rst_h0_done", 32'(m_h0_done), 32'd0);
      @(posedge clk); #1;
      h0_addr = '0; h0_ren = 1'b0;
      @(posedge clk); #1;
      rst      = 1'b0;
      tgt_wait = 0;
      do_req(0, 1'b0, 32'h204, 32'h0, 4'b0000, 32'hA000_0004, 1'b0, lat0);
      check("post_rst_lat", 32'(lat0), 32'd2);

      // back-to-back h0 reads: one done every two cycles
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         do_req(0, 1'b0, b2b_addr[i], 32'h0, 4'b0000, b2b_exp[i], 1'b0, lat0);
         check("b2b_lat", 32'(lat0), 32'd2);
      end

      // fixed priority: h0 held continuously starves h1 until it stops
      rst = 1'b1;
      @(posedge clk); #1;
      use_fp = 1'b1;
      rst_fp = 1'b0;
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               do_req(0, 1'b0, b2b_addr[i], 32'h0, 4'b0000, b2b_exp[i], 1'b0, lat0);
               check("fp_h0_lat", 32'(lat0), 32'd2);
            end
         end
         do_req(1, 1'b0, 32'h30, 32'h0, 4'b0000, 32'h0BAD_CAFE, 1'b0, lat1);
      join
      check("fp_h1_lat", 32'(lat1), 32'd8);

      repeat (2) @(negedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
